// File: rtl/tx_if.sv
// Parallel-side handshake and serial line of the tx serialiser.
// The requester (master) drives data/start/ack; the tx block (slave) drives the line and status.
interface tx_if;
  logic [7:0] tx_pi;
  logic       tx_start;
  logic       tx_data_ack;
  logic       tx_so;
  logic       tx_busy;
  logic       tx_done;

  modport master (
    output tx_pi, tx_start, tx_data_ack,
    input  tx_so, tx_busy, tx_done
  );

  modport slave (
    input  tx_pi, tx_start, tx_data_ack,
    output tx_so, tx_busy, tx_done
  );
endinterface

// File: rtl/tx.sv
// Asynchronous serial transmitter: start bit, 8 data bits MSB first, STOP_BITS stop bits.
// Define TX_PARITY_EN to insert an even-parity bit between the data and the stop bits.
module tx #(
  parameter int CLKS_PER_BIT = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic clk,
  input  logic rst,
  tx_if.slave  bus
);

  localparam int BAUD_W = $clog2(STOP_BITS * CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BIT_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] STOP_LAST = BAUD_W'(STOP_BITS * CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef TX_PARITY_EN
    PARITY,
`endif
    STOP,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        shift_q, shift_d;
  logic [3:0]        bit_q, bit_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic              so_q, so_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
`ifdef TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      bit_q    <= '0;
      baud_q   <= '0;
      so_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bit_q    <= bit_d;
      baud_q   <= baud_d;
      so_q     <= so_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // Outputs are computed one edge ahead so that tx_so/tx_busy/tx_done come straight from flops.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case can infer a latch.
    state_d  = state_q;
    shift_d  = shift_q;
    bit_d    = bit_q;
    baud_d   = (baud_q == '0) ? '0 : baud_q - 1'b1;
    so_d     = so_q;
    busy_d   = busy_q;
    done_d   = done_q;
`ifdef TX_PARITY_EN
    parity_d = parity_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.tx_start) begin
          shift_d  = bus.tx_pi;
          bit_d    = 4'd8;
          baud_d   = BIT_LAST;
          so_d     = 1'b0;
          busy_d   = 1'b1;
          state_d  = START;
`ifdef TX_PARITY_EN
          parity_d = ^bus.tx_pi;
`endif
        end
      end
      START: begin
        if (baud_q == '0) begin
          state_d = DATA;
          so_d    = shift_q[7];
          baud_d  = BIT_LAST;
        end
      end
      DATA: begin
        if (baud_q == '0) begin
          bit_d = bit_q - 4'd1;
          if (bit_q == 4'd1) begin
`ifdef TX_PARITY_EN
            state_d = PARITY;
            so_d    = parity_q;
            baud_d  = BIT_LAST;
`else
            state_d = STOP;
            so_d    = 1'b1;
            baud_d  = STOP_LAST;
`endif
          end else begin
            // The bit after this one is shift_q[6]; it becomes shift_q[7] at this edge.
            shift_d = {shift_q[6:0], 1'b0};
            so_d    = shift_q[6];
            baud_d  = BIT_LAST;
          end
        end
      end
`ifdef TX_PARITY_EN
      PARITY: begin
        if (baud_q == '0) begin
          state_d = STOP;
          so_d    = 1'b1;
          baud_d  = STOP_LAST;
        end
      end
`endif
      STOP: begin
        if (baud_q == '0) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        if (bus.tx_data_ack) begin
          state_d = IDLE;
          done_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.tx_so   = so_q;
  assign bus.tx_busy = busy_q;
  assign bus.tx_done = done_q;

endmodule

// File: tb/tb_tx.sv
// Self-checking bench for tx: per-clock line model plus a mid-bit sampling receiver model.
// Define TX_PARITY_EN here as for the RTL to check the parity frame.
module tb_tx;
  localparam int C = 8;
  localparam int S = 1;
`ifdef TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int L = (9 + PB + S) * C;

  logic clk = 1'b0;
  logic rst;
  tx_if bus ();

  tx #(.CLKS_PER_BIT(C), .STOP_BITS(S)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   vectors = 0;
  int   fails   = 0;
  logic line_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s at %0t: observed %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Expected line level k clocks after the accept edge, from the frame format alone.
  function automatic logic exp_bit(input logic [7:0] d, input int k);
    int idx;
    idx = k / C;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[8 - idx];
    if (PB == 1 && idx == 9) return ^d;
    return 1'b1;
  endfunction

  // Called at a negedge while the DUT is idle. poke >= 0 pulses tx_start with new tx_pi mid-frame.
  task automatic send(input logic [7:0] d, input int poke, input int hold, input logic start_in_done);
    logic [7:0] rx;
    logic       idle_prev;
    idle_prev = bus.tx_so;
    chk("pre_busy", bus.tx_busy, 1'b0);
    line_q.delete();
    bus.tx_pi    = d;
    bus.tx_start = 1'b1;
    for (int k = 0; k < L; k++) begin
      @(negedge clk);
      if (k == 0) bus.tx_start = 1'b0;
      chk("frame_so", bus.tx_so, exp_bit(d, k));
      chk("frame_busy", bus.tx_busy, 1'b1);
      chk("frame_done", bus.tx_done, 1'b0);
      line_q.push_back(bus.tx_so);
      if (k == poke) begin
        bus.tx_start = 1'b1;
        bus.tx_pi    = 8'h00;
      end
      if (k == poke + 1) bus.tx_start = 1'b0;
    end
    // Receiver view: falling edge from idle, then one sample in the middle of each bit.
    for (int i = 0; i < 8; i++) rx[7 - i] = line_q[(1 + i) * C + C / 2];
    chk("rx_edge", {idle_prev, line_q[C / 2]}, 2'b10);
    chk("rx_po", rx, d);
`ifdef TX_PARITY_EN
    chk("rx_parity", line_q[9 * C + C / 2], ^d);
`endif
    chk("rx_stop", line_q[(9 + PB) * C + C / 2], 1'b1);
    @(negedge clk);
    chk("end_busy", bus.tx_busy, 1'b0);
    chk("end_done", bus.tx_done, 1'b1);
    chk("end_so", bus.tx_so, 1'b1);
    for (int h = 0; h < hold; h++) begin
      if (start_in_done) bus.tx_start = 1'b1;
      @(negedge clk);
      chk("hold_done", bus.tx_done, 1'b1);
      chk("hold_busy", bus.tx_busy, 1'b0);
    end
    bus.tx_data_ack = 1'b1;
    if (start_in_done) bus.tx_start = 1'b1;
    @(negedge clk);
    bus.tx_data_ack = 1'b0;
    bus.tx_start    = 1'b0;
    chk("ack_done", bus.tx_done, 1'b0);
    chk("ack_busy", bus.tx_busy, 1'b0);
    chk("ack_so", bus.tx_so, 1'b1);
  endtask

  initial begin
    logic [7:0] d;
    bus.tx_pi       = 8'h00;
    bus.tx_start    = 1'b1;
    bus.tx_data_ack = 1'b0;
    rst             = 1'b1;

    // Reset held two clocks with tx_start high: nothing may start.
    repeat (2) begin
      @(negedge clk);
      chk("rst_so", bus.tx_so, 1'b1);
      chk("rst_busy", bus.tx_busy, 1'b0);
      chk("rst_done", bus.tx_done, 1'b0);
    end
    rst          = 1'b0;
    bus.tx_start = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", bus.tx_busy, 1'b0);

    // Directed frames; the 0x3C/0xFF/0x00 run is back-to-back with the minimum gap.
    send(8'hA5, -1, 2, 1'b0);
    send(8'h3C, -1, 0, 1'b0);
    send(8'hFF, -1, 0, 1'b0);
    send(8'h00, -1, 0, 1'b0);
    send(8'h07, -1, 1, 1'b1);
    send(8'h03, -1, 0, 1'b0);

    // tx_start/tx_pi disturbed mid-DATA: frame unchanged, no second frame.
    send(8'h81, 3 * C + 3, 1, 1'b0);
    repeat (12) begin
      @(negedge clk);
      chk("no_refire_busy", bus.tx_busy, 1'b0);
      chk("no_refire_done", bus.tx_done, 1'b0);
    end

    // Reset during data bit 3 aborts the frame cleanly.
    bus.tx_pi    = 8'hC3;
    bus.tx_start = 1'b1;
    for (int k = 0; k < 4 * C + 3; k++) begin
      @(negedge clk);
      if (k == 0) bus.tx_start = 1'b0;
      chk("abort_so", bus.tx_so, exp_bit(8'hC3, k));
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_so_idle", bus.tx_so, 1'b1);
    chk("abort_busy", bus.tx_busy, 1'b0);
    chk("abort_done", bus.tx_done, 1'b0);
    repeat (2 * C) begin
      @(negedge clk);
      chk("abort_quiet_done", bus.tx_done, 1'b0);
      chk("abort_quiet_so", bus.tx_so, 1'b1);
    end
    send(8'h5A, -1, 0, 1'b0);

    // Random data, hold times, start-in-DONE and mid-frame disturbances.
    repeat (8) begin
      d = 8'($urandom);
      send(d, ($urandom_range(0, 1) == 1) ? int'($urandom_range(C, 9 * C - 3)) : -1,
           int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
